// File: rtl/sccb_reg_target.sv
// SCCB/I2C register target: 7-bit device address, 16-bit register pointer, 8-bit data.
// Define SCCB_TARGET_AUTOINC_EN to advance the pointer after each written or master-ACKed read byte.
`timescale 1ns/1ps

// state    | meaning
// IDLE     | bus free, waiting for START
// DEV      | shifting device address + R/W
// DEV_ACK  | ACK low-high-low after device byte; read path launches first fetch
// ADH      | shifting register address high byte
// ADH_ACK  | ACK after high address byte
// ADL      | shifting register address low byte
// ADL_ACK  | ACK after low address byte
// WDAT     | shifting write data byte
// WDAT_ACK | ACK after write data byte
// RDAT     | driving read data bits
// RDAT_ACK | SDA released, sampling master ACK/NACK
// IGNORE   | not addressed or NACKed, wait for START/STOP
module sccb_reg_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h3C,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, ADH, ADH_ACK, ADL, ADL_ACK,
        WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE
    } state_t;

    localparam logic [2:0] FILT_RELOAD = 3'(FILTER_LEN - 1);

    logic       r_scl_s1, r_scl_s2, r_scl_f, r_scl_q;
    logic       r_sda_s1, r_sda_s2, r_sda_f, r_sda_q;
    logic [2:0] r_scl_cnt, r_sda_cnt;

    state_t      r_state;
    state_t      w_ack_next;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_rw, r_ack_on, r_load;
    logic        r_sda_oe, r_wr_en, r_rd_en, r_busy;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    // Synchronizer followed by a stable-count filter; the filter counter reloads on any agreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1  <= 1'b1; r_scl_s2 <= 1'b1; r_scl_f <= 1'b1; r_scl_q <= 1'b1;
            r_sda_s1  <= 1'b1; r_sda_s2 <= 1'b1; r_sda_f <= 1'b1; r_sda_q <= 1'b1;
            r_scl_cnt <= FILT_RELOAD;
            r_sda_cnt <= FILT_RELOAD;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_scl_q  <= r_scl_f;
            r_sda_q  <= r_sda_f;
            if (r_scl_s2 == r_scl_f) begin
                r_scl_cnt <= FILT_RELOAD;
            end else if (r_scl_cnt == 3'd0) begin
                r_scl_f   <= r_scl_s2;
                r_scl_cnt <= FILT_RELOAD;
            end else begin
                r_scl_cnt <= r_scl_cnt - 3'd1;
            end
            if (r_sda_s2 == r_sda_f) begin
                r_sda_cnt <= FILT_RELOAD;
            end else if (r_sda_cnt == 3'd0) begin
                r_sda_f   <= r_sda_s2;
                r_sda_cnt <= FILT_RELOAD;
            end else begin
                r_sda_cnt <= r_sda_cnt - 3'd1;
            end
        end
    end

    assign w_scl_rise = r_scl_f & ~r_scl_q;
    assign w_scl_fall = ~r_scl_f & r_scl_q;
    assign w_start    = r_scl_f & r_scl_q & r_sda_q & ~r_sda_f;
    assign w_stop     = r_scl_f & r_scl_q & ~r_sda_q & r_sda_f;
    assign w_byte     = {r_shift[6:0], r_sda_f};

    always_comb begin
        w_ack_next = IGNORE;
        case (r_state)
            DEV_ACK:  w_ack_next = r_rw ? RDAT : ADH;
            ADH_ACK:  w_ack_next = ADL;
            ADL_ACK:  w_ack_next = WDAT;
            WDAT_ACK: w_ack_next = WDAT;
            default:  w_ack_next = IGNORE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_rw      <= 1'b0;
            r_ack_on  <= 1'b0;
            r_load    <= 1'b0;
            r_sda_oe  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= 16'h0000;
            r_wdata   <= 8'h00;
        end else begin
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            r_load  <= r_rd_en;
            if (r_load) r_shift <= reg_rdata;
`ifdef SCCB_TARGET_AUTOINC_EN
            if (r_wr_en) r_addr <= r_addr + 16'd1;
`endif
            if (w_stop) begin
                r_state   <= IDLE;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_ack_on  <= 1'b0;
            end else if (w_start) begin
                r_state   <= DEV;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b1;
                r_bit_cnt <= 3'd0;
                r_ack_on  <= 1'b0;
            end else begin
                case (r_state)
                    DEV, ADH, ADL, WDAT: if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            case (r_state)
                                DEV: if (w_byte[7:1] == DEV_ADDR) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= DEV_ACK;
                                end else begin
                                    r_state <= IGNORE;
                                    r_busy  <= 1'b0;
                                end
                                ADH: begin
                                    r_addr[15:8] <= w_byte;
                                    r_state      <= ADH_ACK;
                                end
                                ADL: begin
                                    r_addr[7:0] <= w_byte;
                                    r_state     <= ADL_ACK;
                                end
                                default: begin
                                    r_wdata <= w_byte;
                                    r_wr_en <= 1'b1;
                                    r_state <= WDAT_ACK;
                                end
                            endcase
                        end
                    end
                    // First fall opens the ACK slot, second fall closes it (and launches read MSB).
                    DEV_ACK, ADH_ACK, ADL_ACK, WDAT_ACK: if (w_scl_fall) begin
                        if (!r_ack_on) begin
                            r_ack_on <= 1'b1;
                            r_sda_oe <= 1'b1;
                            if (r_state == DEV_ACK && r_rw) r_rd_en <= 1'b1;
                        end else begin
                            r_ack_on  <= 1'b0;
                            r_bit_cnt <= 3'd0;
                            r_state   <= w_ack_next;
                            r_sda_oe  <= (r_state == DEV_ACK && r_rw) ? ~r_shift[7] : 1'b0;
                        end
                    end
                    RDAT: if (w_scl_rise) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_bit_cnt <= 3'd0;
                            r_state   <= RDAT_ACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {r_shift[6:0], 1'b0};
                        end
                    end else if (w_scl_fall) begin
                        r_sda_oe <= ~r_shift[7];
                    end
                    RDAT_ACK: if (w_scl_fall) begin
                        r_sda_oe <= 1'b0;
                    end else if (w_scl_rise) begin
                        if (!r_sda_f) begin
                            r_rd_en <= 1'b1;
                            r_state <= RDAT;
`ifdef SCCB_TARGET_AUTOINC_EN
                            r_addr  <= r_addr + 16'd1;
`endif
                        end else begin
                            r_state <= IGNORE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wr_en = r_wr_en;
    assign reg_rd_en = r_rd_en;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sccb_reg_target.sv
// Directed bench for sccb_reg_target: open-drain bus master model plus a small register-bank read model.
`timescale 1ns/1ps

module tb_sccb_reg_target;
    localparam int Q = 100;
`ifdef SCCB_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [7:0]  reg_rdata;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    sccb_reg_target #(.DEV_ADDR(7'h3C), .FILTER_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = (reg_addr == 16'h300A) ? 8'h56 : (reg_addr[7:0] ^ 8'hA5);

    int          wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
    logic [15:0] wr_addr_log [64];
    logic [7:0]  wr_data_log [64];
    logic [15:0] rd_addr_log [64];

    always @(negedge clk) begin
        if (reg_wr_en) begin
            if (wr_cnt < 64) begin
                wr_addr_log[wr_cnt] = reg_addr;
                wr_data_log[wr_cnt] = reg_wdata;
            end
            wr_cnt++;
        end
        if (reg_rd_en) begin
            if (rd_cnt < 64) rd_addr_log[rd_cnt] = reg_addr;
            rd_cnt++;
        end
        if (sda_oe) oe_cnt++;
    end

    task automatic send_bit(input logic b, output logic s);
        sda_m = b; #Q;
        scl = 1'b1; #Q;
        s = sda_line; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) send_bit(b[i], d);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d, output logic ack_line);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(nack, ack_line);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl = 1'b1; #Q;
        sda_m = 1'b1; #Q; #Q;
    endtask

    task automatic addr_phase(input logic [15:0] a, output logic [2:0] acks);
        logic a0, a1, a2;
        bus_start();
        send_byte(8'h78, a0);
        send_byte(a[15:8], a1);
        send_byte(a[7:0], a2);
        acks = {a0, a1, a2};
    endtask

    task automatic test_reset();
        #(20 * 10);
        rst_n = 1'b1;
        #(10 * 10);
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_tests++; if (reg_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", reg_addr); end
        n_tests++; if (reg_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %h want 00", reg_wdata); end
        n_tests++; if ({reg_wr_en, reg_rd_en, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {reg_wr_en, reg_rd_en, busy}); end
    endtask

    task automatic test_single_write();
        int base = wr_cnt;
        logic [2:0] acks;
        logic a3;
        addr_phase(16'h3008, acks);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_high: got %b want 1", busy); end
        send_byte(8'h82, a3);
        bus_stop();
        n_tests++; if ({acks, a3} !== 4'b0000) begin n_fail++; $display("FAIL single_acks: got %b want 0000", {acks, a3}); end
        n_tests++; if (wr_cnt - base !== 1) begin n_fail++; $display("FAIL single_wr_count: got %0d want 1", wr_cnt - base); end
        n_tests++; if (wr_addr_log[base] !== 16'h3008 || wr_data_log[base] !== 8'h82) begin n_fail++; $display("FAIL single_wr: got %h/%h want 3008/82", wr_addr_log[base], wr_data_log[base]); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_low: got %b want 0", busy); end
        n_tests++; if (reg_addr !== (AUTOINC ? 16'h3009 : 16'h3008)) begin n_fail++; $display("FAIL single_ptr: got %h", reg_addr); end
    endtask

    task automatic test_mismatch();
        int bw = wr_cnt, br = rd_cnt, bo = oe_cnt;
        logic a0, a1, a2, a3;
        bus_start();
        send_byte(8'h7A, a0);
        send_byte(8'h30, a1);
        send_byte(8'h08, a2);
        send_byte(8'h82, a3);
        bus_stop();
        n_tests++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_fail++; $display("FAIL mismatch_acks: got %b want 1111", {a0, a1, a2, a3}); end
        n_tests++; if (oe_cnt - bo !== 0) begin n_fail++; $display("FAIL mismatch_sda_pulled: got %0d cycles want 0", oe_cnt - bo); end
        n_tests++; if ((wr_cnt - bw) + (rd_cnt - br) !== 0) begin n_fail++; $display("FAIL mismatch_strobes: got %0d want 0", (wr_cnt - bw) + (rd_cnt - br)); end
        n_tests++; if (reg_addr !== (AUTOINC ? 16'h3009 : 16'h3008)) begin n_fail++; $display("FAIL mismatch_ptr: got %h", reg_addr); end
    endtask

    task automatic do_read(input string tag);
        int br = rd_cnt;
        logic [2:0] acks;
        logic a3, nack_line;
        logic [7:0] d;
        addr_phase(16'h300A, acks);
        bus_start();
        send_byte(8'h79, a3);
        read_byte(1'b1, d, nack_line);
        n_tests++; if (sda_oe !== 1'b0 || nack_line !== 1'b1) begin n_fail++; $display("FAIL %s_release: got oe=%b line=%b want 0/1", tag, sda_oe, nack_line); end
        bus_stop();
        n_tests++; if ({acks, a3} !== 4'b0000) begin n_fail++; $display("FAIL %s_acks: got %b want 0000", tag, {acks, a3}); end
        n_tests++; if (d !== 8'h56) begin n_fail++; $display("FAIL %s_data: got %b want 01010110", tag, d); end
        n_tests++; if (rd_cnt - br !== 1 || rd_addr_log[br] !== 16'h300A) begin n_fail++; $display("FAIL %s_rd_en: got %0d at %h want 1 at 300A", tag, rd_cnt - br, rd_addr_log[br]); end
        n_tests++; if (reg_addr !== 16'h300A) begin n_fail++; $display("FAIL %s_ptr: got %h want 300A", tag, reg_addr); end
    endtask

    task automatic test_random_read();
        do_read("read");
    endtask

    task automatic test_read_burst();
        int br = rd_cnt;
        logic [2:0] acks;
        logic a3, l0, l1;
        logic [7:0] d0, d1;
        addr_phase(16'h300A, acks);
        bus_start();
        send_byte(8'h79, a3);
        read_byte(1'b0, d0, l0);
        read_byte(1'b1, d1, l1);
        bus_stop();
        n_tests++; if (d0 !== 8'h56) begin n_fail++; $display("FAIL rburst_d0: got %h want 56", d0); end
        n_tests++; if (d1 !== (AUTOINC ? 8'hAE : 8'h56)) begin n_fail++; $display("FAIL rburst_d1: got %h", d1); end
        n_tests++; if (rd_cnt - br !== 2 || rd_addr_log[br + 1] !== (AUTOINC ? 16'h300B : 16'h300A)) begin n_fail++; $display("FAIL rburst_rd_en: got %0d, second at %h", rd_cnt - br, rd_addr_log[br + 1]); end
    endtask

    task automatic test_burst_write();
        int base = wr_cnt;
        logic [2:0] acks;
        logic a3, a4, a5;
        logic [7:0]  exp_d [3];
        logic [15:0] exp_a [3];
        exp_d[0] = 8'h23; exp_d[1] = 8'h14; exp_d[2] = 8'h0F;
        exp_a[0] = 16'h5800;
        exp_a[1] = AUTOINC ? 16'h5801 : 16'h5800;
        exp_a[2] = AUTOINC ? 16'h5802 : 16'h5800;
        addr_phase(16'h5800, acks);
        send_byte(8'h23, a3);
        send_byte(8'h14, a4);
        send_byte(8'h0F, a5);
        bus_stop();
        n_tests++; if (wr_cnt - base !== 3) begin n_fail++; $display("FAIL burst_count: got %0d want 3", wr_cnt - base); end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (wr_addr_log[base + k] !== exp_a[k] || wr_data_log[base + k] !== exp_d[k]) begin
                n_fail++; $display("FAIL burst_wr%0d: got %h/%h want %h/%h", k, wr_addr_log[base + k], wr_data_log[base + k], exp_a[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int base = wr_cnt;
        logic [2:0] acks;
        logic a3, a4;
        addr_phase(16'hFFFF, acks);
        send_byte(8'h11, a3);
        send_byte(8'h22, a4);
        bus_stop();
        n_tests++; if (wr_addr_log[base + 1] !== (AUTOINC ? 16'h0000 : 16'hFFFF) || wr_data_log[base + 1] !== 8'h22) begin n_fail++; $display("FAIL wrap_second: got %h/%h", wr_addr_log[base + 1], wr_data_log[base + 1]); end
        n_tests++; if (reg_addr !== (AUTOINC ? 16'h0001 : 16'hFFFF)) begin n_fail++; $display("FAIL wrap_ptr: got %h", reg_addr); end
    endtask

    task automatic test_abort();
        int base = wr_cnt;
        logic a0, a1, s;
        logic [2:0] acks;
        logic a3;
        bus_start();
        send_byte(8'h78, a0);
        send_byte(8'h31, a1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, s);
        bus_stop();
        n_tests++; if (wr_cnt - base !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_strobe: got %0d writes busy=%b want 0/0", wr_cnt - base, busy); end
        n_tests++; if (reg_addr[15:8] !== 8'h31) begin n_fail++; $display("FAIL abort_ptr_hi: got %h want 31", reg_addr[15:8]); end
        addr_phase(16'h3103, acks);
        send_byte(8'h02, a3);
        bus_stop();
        n_tests++; if (wr_cnt - base !== 1 || wr_addr_log[base] !== 16'h3103 || wr_data_log[base] !== 8'h02) begin n_fail++; $display("FAIL abort_followup: got %0d writes %h/%h want 1 3103/02", wr_cnt - base, wr_addr_log[base], wr_data_log[base]); end
    endtask

    task automatic test_reset_mid_read();
        logic [2:0] acks;
        logic a3;
        addr_phase(16'h300A, acks);
        bus_start();
        send_byte(8'h79, a3);
        n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midread_driving: got %b want 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midread_oe_release: got %b want 0", sda_oe); end
        n_tests++; if ({reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy} !== 27'd0) begin n_fail++; $display("FAIL midread_reset_vals: got %h %h %b%b%b", reg_addr, reg_wdata, reg_wr_en, reg_rd_en, busy); end
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        rst_n = 1'b1; #(2 * Q);
        do_read("postreset");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_mismatch();
        test_random_read();
        test_read_burst();
        test_burst_write();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
